// File: rtl/vga_cell_pkg.sv
// Shared types and constants for the VGA cell buffer.
//   cmd_op_e : command opcodes carried on cmd_op
//   state_e  : buffer controller states
//   clip_end : last in-grid coordinate of a span starting at origin with length len
package vga_cell_pkg;

  localparam int unsigned CELL_H_LEN_DEFAULT = 52;
  localparam int unsigned CELL_V_LEN_DEFAULT = 40;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_FILL  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  // 7-bit sum so origin + len never wraps before clipping against the grid edge.
  function automatic logic [5:0] clip_end(logic [5:0] origin, logic [5:0] len,
                                          int unsigned limit);
    logic [6:0] sum;
    sum = {1'b0, origin} + {1'b0, len};
    if (32'(sum) > limit) begin
      return 6'(limit - 1);
    end
    return 6'(sum - 7'd1);
  endfunction

endpackage

// File: rtl/vga_cell_sweeper.sv
// Rectangle address walker: visits every cell of [x0..x_end] x [y0..y_end] in row-major
// order, one cell per step.
//   CLK_IN, RST  : clock, asynchronous active-low reset
//   start        : load origin and bounds; cur = (x0, y0)
//   step         : advance to the next cell
//   x0, y0       : rectangle origin (sampled on start)
//   x_end, y_end : inclusive rectangle end (sampled on start)
//   cur_x, cur_y : current cell
//   last         : current cell is (x_end, y_end)
module vga_cell_sweeper
  import vga_cell_pkg::*;
(
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       start,
  input  logic       step,
  input  logic [5:0] x0,
  input  logic [5:0] y0,
  input  logic [5:0] x_end,
  input  logic [5:0] y_end,
  output logic [5:0] cur_x,
  output logic [5:0] cur_y,
  output logic       last
);

  logic [5:0] x0_q, x0_d;
  logic [5:0] x_end_q, x_end_d;
  logic [5:0] y_end_q, y_end_d;
  logic [5:0] cur_x_q, cur_x_d;
  logic [5:0] cur_y_q, cur_y_d;

  always_comb begin
    x0_d    = x0_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (start) begin
      x0_d    = x0;
      x_end_d = x_end;
      y_end_d = y_end;
      cur_x_d = x0;
      cur_y_d = y0;
    end else if (step) begin
      if (cur_x_q < x_end_q) begin
        cur_x_d = cur_x_q + 6'd1;
      end else begin
        cur_x_d = x0_q;
        cur_y_d = cur_y_q + 6'd1;
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      x0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
    end else begin
      x0_q    <= x0_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
    end
  end

  assign cur_x = cur_x_q;
  assign cur_y = cur_y_q;
  assign last  = (cur_x_q == x_end_q) && (cur_y_q == y_end_q);

endmodule

// File: rtl/vga_cell_buffer.sv
// Cell grid for the VGA drawer. Upstream issues WRITE / FILL / CLEAR over valid/ready;
// FILL and CLEAR are serialised into one cell write per clock.
//   CLK_IN, RST      : clock, asynchronous active-low reset
//   cmd_valid/ready  : command handshake (ready only while idle)
//   cmd_op           : 0 NOP, 1 WRITE, 2 FILL, 3 CLEAR
//   cmd_x, cmd_y     : cell (WRITE) or rectangle origin (FILL)
//   cmd_w, cmd_h     : FILL size in cells
//   cmd_value        : value to store
//   busy             : sweep in progress
//   done             : one-cycle pulse after the last sweep write
//   err              : one-cycle pulse after a rejected command
//   values           : grid, index = y * CELL_HORIZONTAL_LENGHT + x
module vga_cell_buffer
  import vga_cell_pkg::*;
#(
  parameter int unsigned CELL_HORIZONTAL_LENGHT = CELL_H_LEN_DEFAULT,
  parameter int unsigned CELL_VERTICAL_LENGHT   = CELL_V_LEN_DEFAULT,
  parameter int          CLEAR_VALUE            = 0
) (
  input  logic        CLK_IN,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_x,
  input  logic [5:0]  cmd_y,
  input  logic [5:0]  cmd_w,
  input  logic [5:0]  cmd_h,
  input  logic [31:0] cmd_value,
  output logic        busy,
  output logic        done,
  output logic        err,
  output int          values [CELL_HORIZONTAL_LENGHT*CELL_VERTICAL_LENGHT]
);

  localparam int unsigned NumCells = CELL_HORIZONTAL_LENGHT * CELL_VERTICAL_LENGHT;
  localparam int unsigned IdxW     = $clog2(NumCells);

  function automatic logic [IdxW-1:0] cell_idx(logic [5:0] x, logic [5:0] y);
    return IdxW'(y) * IdxW'(CELL_HORIZONTAL_LENGHT) + IdxW'(x);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  cmd_op_e     op;
  logic        x_ok, y_ok;

  logic        sw_start;
  logic [5:0]  sw_x0, sw_y0, sw_x_end, sw_y_end;
  logic [5:0]  cur_x, cur_y;
  logic        sw_last;

  logic            wr_en;
  logic [IdxW-1:0] wr_idx;
  logic [31:0]     wr_data;

  assign op   = cmd_op_e'(cmd_op);
  assign x_ok = 32'(cmd_x) < CELL_HORIZONTAL_LENGHT;
  assign y_ok = 32'(cmd_y) < CELL_VERTICAL_LENGHT;

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    err_d    = 1'b0;
    done_d   = 1'b0;
    sw_start = 1'b0;
    sw_x0    = cmd_x;
    sw_y0    = cmd_y;
    sw_x_end = clip_end(cmd_x, cmd_w, CELL_HORIZONTAL_LENGHT);
    sw_y_end = clip_end(cmd_y, cmd_h, CELL_VERTICAL_LENGHT);
    wr_en    = 1'b0;
    wr_idx   = cell_idx(cmd_x, cmd_y);
    wr_data  = cmd_value;
    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready is high throughout IDLE, so cmd_valid alone means accept.
        if (cmd_valid) begin
          case (op)
            CMD_NOP: ;
            CMD_WRITE: begin
              if (x_ok && y_ok) wr_en = 1'b1;
              else              err_d = 1'b1;
            end
            CMD_FILL: begin
              if (x_ok && y_ok && (cmd_w != '0) && (cmd_h != '0)) begin
                sw_start = 1'b1;
                value_d  = cmd_value;
                state_d  = ST_SWEEP;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_CLEAR: begin
              sw_start = 1'b1;
              sw_x0    = '0;
              sw_y0    = '0;
              sw_x_end = 6'(CELL_HORIZONTAL_LENGHT - 1);
              sw_y_end = 6'(CELL_VERTICAL_LENGHT - 1);
              value_d  = CLEAR_VALUE;
              state_d  = ST_SWEEP;
            end
          endcase
        end
      end
      ST_SWEEP: begin
        wr_en   = 1'b1;
        wr_idx  = cell_idx(cur_x, cur_y);
        wr_data = value_q;
        if (sw_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      value_q <= CLEAR_VALUE;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  vga_cell_sweeper u_sweeper (
    .CLK_IN (CLK_IN),
    .RST    (RST),
    .start  (sw_start),
    .step   (state_q == ST_SWEEP),
    .x0     (sw_x0),
    .y0     (sw_y0),
    .x_end  (sw_x_end),
    .y_end  (sw_y_end),
    .cur_x  (cur_x),
    .cur_y  (cur_y),
    .last   (sw_last)
  );

  // One register per cell with a shared single write port.
  for (genvar g = 0; g < NumCells; g++) begin : g_cell
    always_ff @(posedge CLK_IN or negedge RST) begin
      if (!RST) begin
        values[g] <= CLEAR_VALUE;
      end else if (wr_en && (wr_idx == IdxW'(g))) begin
        values[g] <= wr_data;
      end
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SWEEP);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vga_cell_buffer.sv
// Scoreboard bench for vga_cell_buffer: stimulus pushes expected responses, a negedge
// monitor pops one whenever the DUT responds (WRITE accepted, err or done pulse).
module tb_vga_cell_buffer;

  localparam int H = 52;
  localparam int V = 40;
  localparam int N = H * V;

  logic        CLK_IN;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [31:0] cmd_value;
  logic        busy, done, err;
  int          values [N];

  vga_cell_buffer dut (
    .CLK_IN    (CLK_IN),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_value (cmd_value),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .values    (values)
  );

  initial begin
    CLK_IN = 1'b0;
    forever #20 CLK_IN = ~CLK_IN;
  end

  typedef struct packed {
    logic             err;
    logic             done;
    logic [11:0]      busy_len;
    logic             all;
    logic [31:0]      all_val;
    logic [2:0]       n;
    logic [5:0][11:0] idx;
    logic [5:0][31:0] val;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  exp_t  pend;
  string pend_name;

  int checks   = 0;
  int passes   = 0;
  int extra    = 0;
  int timeouts = 0;

  function automatic void chk(string nm, int act, int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endfunction

  function automatic int count_ne(int v);
    int c = 0;
    for (int i = 0; i < N; i++) if (values[i] != v) c++;
    return c;
  endfunction

  function automatic void exp_begin(string nm, bit e, bit d, int bl);
    pend          = '0;
    pend.err      = e;
    pend.done     = d;
    pend.busy_len = 12'(bl);
    pend_name     = nm;
  endfunction

  function automatic void exp_cell(int i, int v);
    pend.idx[pend.n] = 12'(i);
    pend.val[pend.n] = v;
    pend.n           = pend.n + 3'd1;
  endfunction

  function automatic void exp_all(int v);
    pend.all     = 1'b1;
    pend.all_val = v;
  endfunction

  function automatic void exp_push();
    exp_q.push_back(pend);
    name_q.push_back(pend_name);
  endfunction

  // Monitor: one response event per cycle at most.
  int   busy_cnt = 0;
  logic prev_acc = 1'b0;

  always @(negedge CLK_IN) begin
    exp_t  e;
    string nm;
    if (!RST) begin
      busy_cnt = 0;
      prev_acc = 1'b0;
    end else begin
      if (prev_acc || err || done) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          chk({nm, " err"}, int'(err), int'(e.err));
          chk({nm, " done"}, int'(done), int'(e.done));
          if (e.done) chk({nm, " busy cycles"}, busy_cnt, int'(e.busy_len));
          for (int k = 0; k < int'(e.n); k++)
            chk($sformatf("%s cell %0d", nm, e.idx[k]), values[e.idx[k]], int'(e.val[k]));
          if (e.all) chk({nm, " cells differing"}, count_ne(int'(e.all_val)), 0);
        end
        if (done) busy_cnt = 0;
      end
      if (busy) busy_cnt++;
      prev_acc = cmd_valid && cmd_ready && (cmd_op == 2'd1);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input int x, input int y, input int w,
                       input int h, input int v);
    int n;
    cmd_op    = op;
    cmd_x     = 6'(x);
    cmd_y     = 6'(y);
    cmd_w     = 6'(w);
    cmd_h     = 6'(h);
    cmd_value = v;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge CLK_IN);
    while (!cmd_ready && n < 3000) begin
      @(negedge CLK_IN);
      n++;
    end
    if (!cmd_ready) timeouts++;
    @(posedge CLK_IN);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  task automatic write_exp(input int x, input int y, input int v);
    exp_begin($sformatf("write(%0d,%0d)", x, y), 1'b0, 1'b0, 0);
    exp_cell(y * H + x, v);
    exp_push();
    issue(2'd1, x, y, 0, 0, v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int rx, ry;
    RST       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_value = '0;
    repeat (3) @(posedge CLK_IN);
    #1;
    RST = 1'b1;

    // Reset state
    @(negedge CLK_IN);
    chk("reset cmd_ready", int'(cmd_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    chk("reset cells nonzero", count_ne(0), 0);
    @(posedge CLK_IN);
    #1;

    // Single and back-to-back writes
    write_exp(3, 2, 65);
    exp_begin("write(0,0)", 1'b0, 1'b0, 0);
    exp_cell(0, 11);
    exp_cell(2079, 0);
    exp_push();
    issue(2'd1, 0, 0, 0, 0, 11);
    exp_begin("write(51,39)", 1'b0, 1'b0, 0);
    exp_cell(2079, 22);
    exp_cell(0, 11);
    exp_push();
    issue(2'd1, 51, 39, 0, 0, 22);

    // Out-of-range write: x=52 must not alias onto cell 52
    exp_begin("write oob x", 1'b1, 1'b0, 0);
    exp_cell(52, 0);
    exp_cell(0, 11);
    exp_cell(107, 65);
    exp_push();
    issue(2'd1, 52, 0, 0, 0, 99);
    @(negedge CLK_IN);
    chk("cmd_ready after reject", int'(cmd_ready), 1);
    @(posedge CLK_IN);
    #1;
    exp_begin("write oob y", 1'b1, 1'b0, 0);
    exp_cell(2079, 22);
    exp_push();
    issue(2'd1, 0, 40, 0, 0, 98);

    // FILL rejections
    exp_begin("fill w=0", 1'b1, 1'b0, 0);
    exp_cell(53, 0);
    exp_push();
    issue(2'd2, 1, 1, 0, 3, 5);
    exp_begin("fill x oob", 1'b1, 1'b0, 0);
    exp_push();
    issue(2'd2, 52, 1, 2, 2, 5);

    // Interior FILL 3x2 at (10,5): rows start at 270 and 322
    exp_begin("fill 3x2", 1'b0, 1'b1, 6);
    exp_cell(270, 4);
    exp_cell(272, 4);
    exp_cell(322, 4);
    exp_cell(324, 4);
    exp_cell(273, 0);
    exp_cell(269, 0);
    exp_push();
    issue(2'd2, 10, 5, 3, 2, 4);

    // Clipped FILL at the bottom-right corner
    exp_begin("fill clipped", 1'b0, 1'b1, 4);
    exp_cell(2026, 7);
    exp_cell(2027, 7);
    exp_cell(2078, 7);
    exp_cell(2079, 7);
    exp_cell(2025, 0);
    exp_cell(1975, 0);
    exp_push();
    issue(2'd2, 50, 38, 5, 5, 7);

    // Random writes, then CLEAR with a WRITE held across the sweep
    for (int i = 0; i < 4; i++) begin
      rx = int'($urandom_range(0, H - 1));
      ry = int'($urandom_range(0, V - 1));
      write_exp(rx, ry, 100 + i);
    end
    exp_begin("clear", 1'b0, 1'b1, N);
    exp_all(0);
    exp_push();
    issue(2'd3, 0, 0, 0, 0, 0);
    exp_begin("held write", 1'b0, 1'b0, 0);
    exp_cell(265, 33);
    exp_cell(266, 0);
    exp_push();
    issue(2'd1, 5, 5, 0, 0, 33);

    // Reset in cycle 3 of a 10-cycle FILL
    issue(2'd2, 0, 0, 10, 1, 9);
    @(posedge CLK_IN);
    #1;
    @(posedge CLK_IN);
    #1;
    chk("partial fill cell 1", values[1], 9);
    RST = 1'b0;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort cmd_ready", int'(cmd_ready), 1);
    chk("abort cells nonzero", count_ne(0), 0);
    @(posedge CLK_IN);
    #1;
    RST = 1'b1;
    exp_begin("fill after abort", 1'b0, 1'b1, 10);
    exp_cell(0, 5);
    exp_cell(9, 5);
    exp_cell(10, 0);
    exp_cell(52, 0);
    exp_push();
    issue(2'd2, 0, 0, 10, 1, 5);

    repeat (20) @(posedge CLK_IN);
    #1;
    chk("responses outstanding", exp_q.size(), 0);
    chk("unexpected responses", extra, 0);
    chk("accept timeouts", timeouts, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_cell_buffer.md
Name: vga_cell_buffer

Overview:
- Holds the character/cell grid that the VGA drawer renders. Presents it as the flat `values` array, row-major, one int per cell.
- Game/control logic sits upstream and issues cell commands over a valid/ready handshake.
- Commands: single-cell WRITE, rectangular FILL, full-grid CLEAR.
- The buffer serialises FILL and CLEAR into one cell write per clock.

Parameters:
- CELL_HORIZONTAL_LENGHT, 52, number of cell columns.
- CELL_VERTICAL_LENGHT, 40, number of cell rows.
- CLEAR_VALUE, 0, int written to every cell by CLEAR and by reset.

Ports:
- CLK_IN  in  1  25 MHz pixel/system clock.
- RST  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  buffer accepts a command this cycle.
- cmd_op  in  2  0=NOP, 1=WRITE, 2=FILL, 3=CLEAR.
- cmd_x  in  6  column of cell (WRITE) or rectangle origin (FILL).
- cmd_y  in  6  row of cell (WRITE) or rectangle origin (FILL).
- cmd_w  in  6  FILL width in cells.
- cmd_h  in  6  FILL height in cells.
- cmd_value  in  32  int value to store.
- busy  out  1  FILL/CLEAR sweep in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- err  out  1  one-cycle pulse when a command is rejected.
- values  out  int[CELL_HORIZONTAL_LENGHT*CELL_VERTICAL_LENGHT]  cell grid, index = y*CELL_HORIZONTAL_LENGHT + x.

Behaviour:
- Reset (async, RST=0):
  - all values = CLEAR_VALUE; state IDLE.
  - cmd_ready=1, busy=0, done=0, err=0.
  - Reset during a sweep aborts it; no partial state survives.
- Handshake and states:
  - Accept occurs on a rising edge with cmd_valid & cmd_ready.
  - cmd_ready = (state==IDLE).
  - Command fields are sampled only at accept.
- FSM states: IDLE, SWEEP.
- IDLE:
  - NOP: no effect.
  - WRITE with x<H_LEN and y<V_LEN: cell written at the accept edge, visible on values the following cycle (1-cycle latency). Stays IDLE, so back-to-back WRITEs sustain 1 per clock.
  - WRITE out of range: values unchanged, err=1 for one cycle.
  - FILL:
    - Rejected with an err pulse (stays IDLE) if w==0, h==0, x>=H_LEN or y>=V_LEN.
    - Otherwise latch x0=x, y0=y, value.
    - Clip: x_end = min(x+w, H_LEN)-1, y_end = min(y+h, V_LEN)-1, using 7-bit sums so there is no wrap.
    - Set cur=(x0,y0); go SWEEP.
  - CLEAR: x0=y0=0, x_end=H_LEN-1, y_end=V_LEN-1, value=CLEAR_VALUE; go SWEEP.
- SWEEP:
  - Each cycle writes values[cur_y*H_LEN+cur_x]=latched value.
  - If cur_x<x_end: cur_x++.
  - Else: cur_x=x0 and cur_y++.
  - On the write of (x_end,y_end): done=1 for one cycle, return to IDLE. cmd_ready is high in the next cycle.
  - busy=1 for exactly the sweep cycles.
  - FILL of w×h (after clipping) takes w×h cycles; CLEAR takes H_LEN×V_LEN = 2080 cycles.
- Simultaneous events:
  - cmd_valid while busy is ignored (not accepted, held by upstream).
  - done and err are never high in the same cycle.
- values is register-based.
  - The drawer may sample it at any time; tearing across a frame is acceptable.
  - No frame synchronisation is performed.
- Arithmetic:
  - Index product uses ≥12 bits (max 2079).
  - No multiplier is required in SWEEP; a running index, +1 per column and +(H_LEN−width+1) on row wrap, is permitted if externally equivalent.

Decomposition:
- Package vga_cell_pkg holds:
  - the cmd_op enum (CMD_NOP, CMD_WRITE, CMD_FILL, CMD_CLEAR);
  - the state enum (ST_IDLE, ST_SWEEP);
  - the default grid constants 52/40.
- Single natural sub-module: vga_cell_sweeper, the rectangle address walker.
  - Inputs: start, x0, y0, x_end, y_end.
  - Outputs: cur_x, cur_y, last.
  - The top level owns the storage array and the handshake.

Test Plan:
- Reset: after RST low→high, all 2080 cells == 0, cmd_ready=1, busy=0.
- WRITE x=3,y=2,value=65 → values[107]==65 one cycle after accept. Back-to-back WRITEs to (0,0) and (51,39) → values[0] and values[2079] updated on consecutive cycles.
- WRITE x=52,y=0 → err pulse of 1 cycle, no cell changed, cmd_ready stays 1.
- FILL x=50,y=38,w=5,h=5,value=7 → clipped to a 2×2 area: cells 2026, 2027, 2078, 2079 ==7. busy for 4 cycles, done pulse, neighbours unchanged.
- CLEAR after random writes → busy exactly 2080 cycles, all cells 0. A cmd_valid WRITE held during the sweep is accepted only after done.
- RST asserted mid-FILL (cycle 3 of 10) → immediate abort: busy=0, all cells 0. The next FILL executes normally.
